// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, port-code width and the
// per-output lock state used by the switch arbiter.
package noc_pkg;

  localparam int PORT_L = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_S = 3;
  localparam int PORT_W = 4;

  localparam int PW = 3;
  localparam logic [PW-1:0] IDLE_CODE = '1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request searching upward from ptr+1,
// wrapping modulo NUM_PORTS. Returns the winner one-hot and as an index.
module rr_arbiter #(
  parameter int NUM_PORTS = 5,
  parameter int PW        = 3
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] gnt_oh,
  output logic [PW-1:0]        gnt_idx
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    gnt_oh  = '0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(ptr) + k) % NUM_PORTS;
      if (gnt_oh == '0 && req[idx]) begin
        gnt_oh[idx] = 1'b1;
        gnt_idx     = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/switch_arbiter_rr.sv
// NoC switch arbiter: each output locks onto one input by round-robin and
// holds it (wormhole) until the tail flit transfers or the owner aborts.
module switch_arbiter_rr #(
  parameter int            NUM_PORTS = 5,
  parameter int            PW        = noc_pkg::PW,
  parameter logic [PW-1:0] IDLE_CODE = {PW{1'b1}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS*PW-1:0] request,
  input  logic [NUM_PORTS-1:0]    tail,
  input  logic [NUM_PORTS-1:0]    out_ready,
  output logic [NUM_PORTS-1:0]    grant,
  output logic [NUM_PORTS*PW-1:0] select,
  output logic [NUM_PORTS-1:0]    out_busy
);

  import noc_pkg::state_e;
  import noc_pkg::ST_IDLE;
  import noc_pkg::ST_LOCKED;

  state_e               state_q [NUM_PORTS];
  state_e               state_d [NUM_PORTS];
  logic [PW-1:0]        owner_q [NUM_PORTS];
  logic [PW-1:0]        owner_d [NUM_PORTS];
  logic [PW-1:0]        ptr_q   [NUM_PORTS];
  logic [PW-1:0]        ptr_d   [NUM_PORTS];

  logic [PW-1:0]        req_code [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_locked;
  logic [NUM_PORTS-1:0] arb_req [NUM_PORTS];
  logic [NUM_PORTS-1:0] arb_oh  [NUM_PORTS];
  logic [PW-1:0]        arb_idx [NUM_PORTS];

  // Inputs already owning an output are held off everywhere, so an
  // abort-and-retarget request waits one cycle for the old lock to drop.
  always_comb begin
    in_locked = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (state_q[o] == ST_LOCKED) in_locked[owner_q[o]] = 1'b1;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_code[i] = request[i*PW +: PW];
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      arb_req[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        arb_req[o][i] = (req_code[i] == PW'(o)) && !in_locked[i];
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .PW        (PW)
    ) u_arb (
      .req     (arb_req[o]),
      .ptr     (ptr_q[o]),
      .gnt_oh  (arb_oh[o]),
      .gnt_idx (arb_idx[o])
    );
  end

  // NOTE: state flops use non-blocking assignments so every output's lock
  // updates from the same pre-edge view of all other outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= ST_IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= PW'(NUM_PORTS - 1);
      end
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      case (state_q[o])
        ST_IDLE: begin
          if (|arb_oh[o]) begin
            state_d[o] = ST_LOCKED;
            owner_d[o] = arb_idx[o];
          end
        end
        ST_LOCKED: begin
          // Tail is only honoured on a cycle that actually moves the flit.
          if ((out_ready[o] && tail[owner_q[o]]) ||
              (req_code[owner_q[o]] != PW'(o))) begin
            state_d[o] = ST_IDLE;
            ptr_d[o]   = owner_q[o];
          end
        end
        default: state_d[o] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    grant    = '0;
    select   = '0;
    out_busy = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (state_q[o] == ST_LOCKED) begin
        select[o*PW +: PW] = owner_q[o];
        out_busy[o]        = 1'b1;
        if (out_ready[o]) grant[owner_q[o]] = 1'b1;
      end else begin
        select[o*PW +: PW] = IDLE_CODE;
      end
    end
  end

endmodule

// File: tb/tb_switch_arbiter_rr.sv
// Self-checking bench for switch_arbiter_rr: directed vector table, a
// retarget sequence, then random traffic against a reference model.
module tb_switch_arbiter_rr;

  localparam int NP = 5;
  localparam int PW = 3;

  logic             clk;
  logic             rst;
  logic [NP*PW-1:0] request;
  logic [NP-1:0]    tail;
  logic [NP-1:0]    out_ready;
  logic [NP-1:0]    grant;
  logic [NP*PW-1:0] select;
  logic [NP-1:0]    out_busy;

  int checks   = 0;
  int failures = 0;

  switch_arbiter_rr #(.NUM_PORTS(NP), .PW(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .request   (request),
    .tail      (tail),
    .out_ready (out_ready),
    .grant     (grant),
    .select    (select),
    .out_busy  (out_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic [NP*PW-1:0] req;
    logic [NP-1:0]    tl;
    logic [NP-1:0]    rdy;
    bit               chk;
    logic [NP-1:0]    exp_grant;
    logic [NP*PW-1:0] exp_sel;
    logic [NP-1:0]    exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [NP*PW-1:0] lanes(int c0, int c1, int c2, int c3, int c4);
    return {3'(c4), 3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [NP*PW-1:0] rq, input logic [NP-1:0] tl,
                     input logic [NP-1:0] rd, input bit c, input logic [NP-1:0] eg,
                     input logic [NP*PW-1:0] es, input logic [NP-1:0] eb);
    vec_t v;
    v.rst = r; v.req = rq; v.tl = tl; v.rdy = rd; v.chk = c;
    v.exp_grant = eg; v.exp_sel = es; v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic cyc(input logic r, input logic [NP*PW-1:0] rq, input logic [NP-1:0] tl,
                     input logic [NP-1:0] rd, input bit c, input logic [NP-1:0] eg,
                     input logic [NP*PW-1:0] es, input logic [NP-1:0] eb, input string tag);
    @(negedge clk);
    rst = r; request = rq; tail = tl; out_ready = rd;
    #1;
    if (c) begin
      check({tag, ".grant"},    32'(grant),    32'(eg));
      check({tag, ".select"},   32'(select),   32'(es));
      check({tag, ".out_busy"}, 32'(out_busy), 32'(eb));
    end
  endtask

  // Reference model: per-output lock flag, owner and last-served input.
  bit m_lock [NP];
  int m_own  [NP];
  int m_ptr  [NP];

  function automatic int code_of(logic [NP*PW-1:0] rq, int i);
    logic [NP*PW-1:0] t;
    t = rq >> (i * PW);
    return int'(t[PW-1:0]);
  endfunction

  task automatic model_reset();
    for (int o = 0; o < NP; o++) begin
      m_lock[o] = 1'b0; m_own[o] = 0; m_ptr[o] = NP - 1;
    end
  endtask

  task automatic model_outputs(output logic [NP-1:0] g, output logic [NP*PW-1:0] s,
                               output logic [NP-1:0] b);
    int sel_code [NP];
    g = '0; b = '0;
    for (int o = 0; o < NP; o++) begin
      sel_code[o] = m_lock[o] ? m_own[o] : 7;
      if (m_lock[o]) begin
        b[o] = 1'b1;
        if (out_ready[o]) g[m_own[o]] = 1'b1;
      end
    end
    s = lanes(sel_code[0], sel_code[1], sel_code[2], sel_code[3], sel_code[4]);
  endtask

  task automatic model_step();
    bit busy_in [NP];
    bit n_lock  [NP];
    int n_own   [NP];
    int n_ptr   [NP];
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NP; i++) busy_in[i] = 1'b0;
    for (int o = 0; o < NP; o++) if (m_lock[o]) busy_in[m_own[o]] = 1'b1;
    n_lock = m_lock; n_own = m_own; n_ptr = m_ptr;
    for (int o = 0; o < NP; o++) begin
      if (m_lock[o]) begin
        if ((out_ready[o] && tail[m_own[o]]) || code_of(request, m_own[o]) != o) begin
          n_lock[o] = 1'b0;
          n_ptr[o]  = m_own[o];
        end
      end else begin
        for (int k = 1; k <= NP; k++) begin
          int c;
          c = (m_ptr[o] + k) % NP;
          if (!n_lock[o] && code_of(request, c) == o && !busy_in[c]) begin
            n_lock[o] = 1'b1;
            n_own[o]  = c;
          end
        end
      end
    end
    m_lock = n_lock; m_own = n_own; m_ptr = n_ptr;
  endtask

  initial begin
    logic [NP*PW-1:0] i7, q;
    logic [NP-1:0]    eg, eb;
    logic [NP*PW-1:0] es;
    int cur [NP];

    rst = 1'b1; request = '1; tail = '0; out_ready = '1;
    i7 = lanes(7, 7, 7, 7, 7);

    // Reset then idle
    add(1, i7, 0, '1, 0, 0, i7, 0);
    for (int k = 0; k < 10; k++) add(0, i7, 0, '1, 1, 0, i7, 0);

    // Single 3-flit packet W -> L
    q = lanes(7, 7, 7, 7, 0);
    add(0, q, 0, '1, 1, 0, i7, 0);
    add(0, q, 0, '1, 1, 5'b10000, lanes(4, 7, 7, 7, 7), 5'b00001);
    add(0, q, 0, '1, 1, 5'b10000, lanes(4, 7, 7, 7, 7), 5'b00001);
    add(0, q, 5'b10000, '1, 1, 5'b10000, lanes(4, 7, 7, 7, 7), 5'b00001);
    add(0, i7, 0, '1, 1, 0, i7, 0);

    // Contention N, E, S -> E-out with single-flit packets
    q = lanes(7, 2, 2, 2, 7);
    add(1, i7, 0, '1, 0, 0, i7, 0);
    add(0, q, '1, '1, 1, 0, i7, 0);
    add(0, q, '1, '1, 1, 5'b00010, lanes(7, 7, 1, 7, 7), 5'b00100);
    add(0, q, '1, '1, 1, 0, i7, 0);
    add(0, q, '1, '1, 1, 5'b00100, lanes(7, 7, 2, 7, 7), 5'b00100);
    add(0, q, '1, '1, 1, 0, i7, 0);
    add(0, q, '1, '1, 1, 5'b01000, lanes(7, 7, 3, 7, 7), 5'b00100);
    add(0, q, '1, '1, 1, 0, i7, 0);
    add(0, q, '1, '1, 1, 5'b00010, lanes(7, 7, 1, 7, 7), 5'b00100);
    add(0, i7, 0, '1, 1, 0, i7, 0);

    // Back-pressure on N-out while L's tail is presented
    q = lanes(1, 7, 7, 7, 7);
    add(0, q, 0, '1, 1, 0, i7, 0);
    add(0, q, 0, '1, 1, 5'b00001, lanes(7, 0, 7, 7, 7), 5'b00010);
    for (int k = 0; k < 4; k++)
      add(0, q, 5'b00001, 5'b11101, 1, 0, lanes(7, 0, 7, 7, 7), 5'b00010);
    add(0, q, 0, '1, 1, 5'b00001, lanes(7, 0, 7, 7, 7), 5'b00010);
    add(0, q, 5'b00001, '1, 1, 5'b00001, lanes(7, 0, 7, 7, 7), 5'b00010);
    add(0, i7, 0, '1, 1, 0, i7, 0);

    // Abort on W-out leaves ptr=2, so S beats N; then reset mid-packet
    q = lanes(7, 7, 4, 7, 7);
    add(0, q, 0, '1, 1, 0, i7, 0);
    add(0, q, 0, '1, 1, 5'b00100, lanes(7, 7, 7, 7, 2), 5'b10000);
    add(0, i7, 0, 5'b01111, 1, 0, lanes(7, 7, 7, 7, 2), 5'b10000);
    q = lanes(7, 4, 7, 4, 7);
    add(0, q, 0, '1, 1, 0, i7, 0);
    add(0, q, 0, '1, 1, 5'b01000, lanes(7, 7, 7, 7, 3), 5'b10000);
    add(1, q, 0, '1, 1, 5'b01000, lanes(7, 7, 7, 7, 3), 5'b10000);
    add(0, q, 0, '1, 1, 0, i7, 0);
    add(0, q, '1, '1, 1, 5'b00010, lanes(7, 7, 7, 7, 1), 5'b10000);
    add(0, i7, 0, '1, 1, 0, i7, 0);

    // All five outputs locked in parallel, then invalid codes ignored
    q = lanes(1, 2, 3, 4, 0);
    add(0, q, '1, '1, 1, 0, i7, 0);
    add(0, q, '1, '1, 1, 5'b11111, lanes(4, 0, 1, 2, 3), 5'b11111);
    add(0, q, '1, '1, 1, 0, i7, 0);
    add(0, q, '1, '1, 1, 5'b11111, lanes(4, 0, 1, 2, 3), 5'b11111);
    add(0, i7, 0, '1, 1, 0, i7, 0);
    add(0, lanes(5, 6, 7, 5, 6), 0, '1, 1, 0, i7, 0);
    add(0, lanes(5, 6, 7, 5, 6), 0, '1, 1, 0, i7, 0);

    foreach (vecs[k])
      cyc(vecs[k].rst, vecs[k].req, vecs[k].tl, vecs[k].rdy, vecs[k].chk,
          vecs[k].exp_grant, vecs[k].exp_sel, vecs[k].exp_busy, $sformatf("vec%0d", k));

    // Abort-and-retarget: L moves from N-out to E-out and waits one cycle
    cyc(1, i7, 0, '1, 0, 0, i7, 0, "rt0");
    cyc(0, lanes(1, 7, 7, 7, 7), 0, '1, 1, 0, i7, 0, "rt1");
    cyc(0, lanes(1, 7, 7, 7, 7), 0, '1, 1, 5'b00001, lanes(7, 0, 7, 7, 7), 5'b00010, "rt2");
    cyc(0, lanes(2, 7, 7, 7, 7), 0, 5'b11101, 1, 0, lanes(7, 0, 7, 7, 7), 5'b00010, "rt3");
    cyc(0, lanes(2, 7, 7, 7, 7), 0, '1, 1, 0, i7, 0, "rt4");
    cyc(0, lanes(2, 7, 7, 7, 7), 0, '1, 1, 5'b00001, lanes(7, 7, 0, 7, 7), 5'b00100, "rt5");
    cyc(0, i7, 0, 5'b11011, 1, 0, lanes(7, 7, 0, 7, 7), 5'b00100, "rt6");
    cyc(0, i7, 0, '1, 1, 0, i7, 0, "rt7");

    // Random traffic against the reference model
    cyc(1, i7, 0, '1, 0, 0, i7, 0, "rnd_rst");
    model_reset();
    for (int i = 0; i < NP; i++) cur[i] = 7;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NP; i++)
        if ($urandom_range(0, 99) < 20) cur[i] = $urandom_range(0, 9) > 7 ? 7 : $urandom_range(0, 7);
      @(negedge clk);
      rst       = ($urandom_range(0, 199) == 0);
      request   = lanes(cur[0], cur[1], cur[2], cur[3], cur[4]);
      tail      = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
      out_ready = 5'($urandom_range(0, 31)) | 5'($urandom_range(0, 31));
      #1;
      model_outputs(eg, es, eb);
      check($sformatf("rnd%0d.grant", n),    32'(grant),    32'(eg));
      check($sformatf("rnd%0d.select", n),   32'(select),   32'(es));
      check($sformatf("rnd%0d.out_busy", n), 32'(out_busy), 32'(eb));
      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
